// File: rtl/cla_serial_add16.sv
// cla_serial_add16: multi-cycle WIDTH-bit adder feeding one 4-bit CLA a nibble per cycle, LSB first.
// Define CLA_SERIAL_OVF_FLAG_EN to add the signed-overflow output ovf.
module cla_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] g, p;
    logic [4:0] c;
    assign g    = a & b;
    assign p    = a ^ b;
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign s    = p ^ c[3:0];
    assign cout = c[4];
endmodule

module cla_serial_add16 #(
    parameter int WIDTH  = 16,
    parameter int NSLICE = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_SERIAL_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);
    localparam int IW = $clog2(NSLICE);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic             accept, run, last;
    logic [3:0]       s;
    logic             co;

    cla_4b u_cla (
        .a   (a_q[4*idx_q +: 4]),
        .b   (b_q[4*idx_q +: 4]),
        .cin (carry_q),
        .s   (s),
        .cout(co)
    );

    assign accept = (state_q == IDLE) && in_valid;
    assign run    = (state_q == RUN);
    assign last   = (idx_q == IW'(NSLICE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = in_valid ? RUN : IDLE;
            RUN:     state_d = last ? DONE : RUN;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d     = accept ? a : a_q;
        b_d     = accept ? b : b_q;
        carry_d = accept ? cin : (run ? co : carry_q);
        idx_d   = accept ? '0 : (run ? idx_q + IW'(1) : idx_q);
        cout_d  = (run && last) ? co : cout_q;
        sum_d   = sum_q;
        if (run) sum_d[4*idx_q +: 4] = s;
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        sum       = sum_q;
        cout      = cout_q;
    end

`ifdef CLA_SERIAL_OVF_FLAG_EN
    logic ovf_q;
    logic ovf_d;
    // Top nibble's S[3] is the sum sign bit.
    always_comb begin
        ovf_d = (run && last) ? ((a_q[WIDTH-1] == b_q[WIDTH-1]) && (s[3] != a_q[WIDTH-1])) : ovf_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end
    assign ovf = ovf_q;
`endif
endmodule

// File: doc/cla_serial_add16.md
Name: cla_serial_add16

Overview:
- Multi-cycle wide adder that uses one instance of the team's 4-bit carry-lookahead adder (CLA_4b: A, B, Cin -> S, Cout) as its arithmetic core.
- Captures WIDTH-bit operands through a valid/ready handshake and feeds the CLA_4b one nibble per cycle, LSB nibble first, with the carry registered between slices.
- Assembles the full sum and returns it through an output valid/ready handshake.
- Sits directly upstream of CLA_4b as its operand sequencer and consumes CLA_4b's S/Cout.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 8.
- NSLICE, WIDTH/4, number of nibble slices; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b, cin are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in to nibble 0
- out_valid  output  1  sum/cout valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  registered sum
- cout  output  1  registered carry-out of the MSB nibble

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: FSM=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, slice index=0, carry register=0.
- FSM states are IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register a, b and cin; set carry=cin and idx=0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - CLA_4b inputs are A=a_reg[4*idx+:4], B=b_reg[4*idx+:4], Cin=carry.
  - Each edge: sum[4*idx+:4]<=S, carry<=Cout, idx<=idx+1.
  - When idx==NSLICE-1: also cout<=Cout; go to DONE.
- DONE:
  - out_valid=1; sum and cout are held stable; in_ready=0.
  - On out_ready: go to IDLE, out_valid<=0.
- Timing:
  - Latency: out_valid rises NSLICE edges after the acceptance edge (4 for WIDTH=16).
  - Throughput with out_ready tied high: one operation per NSLICE+2 cycles.
- Arithmetic: {cout,sum} = a+b+cin, modulo 2^(WIDTH+1). No saturation.
- Boundary conditions:
  - in_valid held during RUN/DONE is ignored, with no capture. Upstream must hold its data until in_ready.
  - out_ready asserted before DONE has no effect.
  - out_ready low keeps DONE and the output values indefinitely.
  - Captured operands are immune to a/b/cin changes after acceptance.
  - idx wraps to 0 on entry to RUN only. It is never used outside RUN.
  - rst_n asserted in any state, including mid-RUN, immediately forces reset values. The partial sum is discarded and no out_valid is produced for the aborted operation.
  - rst_n deassertion is synchronised by the integrator. The block only requires reset values to hold while rst_n=0.

Optional Feature:
- Macro: CLA_SERIAL_OVF_FLAG_EN.
- Defined:
  - Adds output port ovf (output, 1), the signed two's-complement overflow.
  - ovf is registered with cout: ovf = (a_reg[WIDTH-1]==b_reg[WIDTH-1]) && (S[3]!=a_reg[WIDTH-1]) on the final RUN edge.
  - Reset value 0; valid only with out_valid.
- Undefined: the ovf port and its logic are absent, and the remaining behaviour is identical.

Test Plan:
- a=16'hFFFF, b=16'h0001, cin=0 -> after 4 cycles out_valid=1, sum=16'h0000, cout=1.
- a=16'h1234, b=16'h4321, cin=1 -> sum=16'h5556, cout=0. in_ready is low from the acceptance edge until return to IDLE.
- Backpressure:
  - a=16'h8000, b=16'h8000, cin=0, with out_ready held low 5 cycles.
  - Required: out_valid stays 1, sum=16'h0000 and cout=1 remain stable, and a new in_valid with a=16'h0001 is not accepted.
  - Then out_ready=1 -> IDLE next cycle.
- Reset mid-RUN: assert rst_n=0 at the second RUN cycle of a=16'hAAAA, b=16'h5555. Required: out_valid=0, sum=0, cout=0, in_ready=1 immediately, and no stale result afterwards.
- Back-to-back with out_ready=1:
  - 16'h0F0F+16'h00F1+0 gives sum=16'h1000, cout=0.
  - 16'hFFFF+16'hFFFF+1 gives sum=16'hFFFF, cout=1.
  - Results are in order, 6 cycles apart.
- With CLA_SERIAL_OVF_FLAG_EN:
  - 16'h7FFF+16'h0001+0 -> sum=16'h8000, ovf=1, cout=0.
  - 16'hFFFF+16'h0001+0 -> ovf=0.
